// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and master IDs.
// Width constant mirrors the CPU datapath width.
package mem_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } master_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: purely combinational, one-hot (or zero) output.
// On a tie the master that did not win last time is chosen.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  master_t    last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = req_i[0] & (~req_i[1] | (last_grant_i == M_LSU));
        grant_o[1] = req_i[1] & (~req_i[0] | (last_grant_i == M_IFU));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write), one transaction in flight.
// Accept at N, memory request at N+1, response passed straight through; one IDLE cycle between transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = CPU_WIDTH,
    parameter int DATA_W = CPU_WIDTH,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ifu_valid,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_ready,
    output logic              o_ifu_rvalid,
    output logic [DATA_W-1:0] o_ifu_rdata,
    input  logic              i_ifu_rready,
    input  logic              i_lsu_valid,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic              i_lsu_wen,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [MASK_W-1:0] i_lsu_wmask,
    output logic              o_lsu_ready,
    output logic              o_lsu_rvalid,
    output logic [DATA_W-1:0] o_lsu_rdata,
    input  logic              i_lsu_rready,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_wmask,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_rready
);

    state_t            state_q, state_d;
    master_t           last_grant_q, last_grant_d;
    master_t           owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [1:0]        grant;
    logic              rsp_rdy;

    rr_arb2 u_rr_arb2 (
        .req_i        ({i_lsu_valid, i_ifu_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rsp_rdy      = 1'b0;
        o_ifu_ready  = 1'b0;
        o_ifu_rvalid = 1'b0;
        o_ifu_rdata  = '0;
        o_lsu_ready  = 1'b0;
        o_lsu_rvalid = 1'b0;
        o_lsu_rdata  = '0;
        o_mem_valid  = 1'b0;
        o_mem_addr   = '0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = '0;
        o_mem_wmask  = '0;
        o_mem_rready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_ifu_ready = grant[0];
                o_lsu_ready = grant[1];
                if (grant[0]) begin
                    owner_d = M_IFU;
                    addr_d  = i_ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = ST_REQ;
                end else if (grant[1]) begin
                    owner_d = M_LSU;
                    addr_d  = i_lsu_addr;
                    wen_d   = i_lsu_wen;
                    wdata_d = i_lsu_wdata;
                    // Reads never carry byte enables to memory.
                    wmask_d = i_lsu_wen ? i_lsu_wmask : '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = addr_q;
                o_mem_wen   = wen_q;
                o_mem_wdata = wdata_q;
                o_mem_wmask = wmask_q;
                if (i_mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_q == M_LSU) begin
                    rsp_rdy      = i_lsu_rready;
                    o_lsu_rvalid = i_mem_rvalid;
                    o_lsu_rdata  = i_mem_rdata;
                end else begin
                    rsp_rdy      = i_ifu_rready;
                    o_ifu_rvalid = i_mem_rvalid;
                    o_ifu_rdata  = i_mem_rdata;
                end
                o_mem_rready = rsp_rdy;
                if (i_mem_rvalid && rsp_rdy) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= M_LSU;
            owner_q      <= M_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled 3ns after the rising edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ifu_valid;
    logic [31:0] i_ifu_addr;
    logic        o_ifu_ready;
    logic        o_ifu_rvalid;
    logic [31:0] o_ifu_rdata;
    logic        i_ifu_rready;
    logic        i_lsu_valid;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_wen;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_wmask;
    logic        o_lsu_ready;
    logic        o_lsu_rvalid;
    logic [31:0] o_lsu_rdata;
    logic        i_lsu_rready;
    logic        o_mem_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_mem_rready;

    int checks;
    int errors;

    logic [138:0] all_out;
    assign all_out = {o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_lsu_ready, o_lsu_rvalid,
                      o_lsu_rdata, o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata,
                      o_mem_wmask, o_mem_rready};

    mem_arbiter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ifu_valid  (i_ifu_valid),
        .i_ifu_addr   (i_ifu_addr),
        .o_ifu_ready  (o_ifu_ready),
        .o_ifu_rvalid (o_ifu_rvalid),
        .o_ifu_rdata  (o_ifu_rdata),
        .i_ifu_rready (i_ifu_rready),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wen    (i_lsu_wen),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_wmask  (i_lsu_wmask),
        .o_lsu_ready  (o_lsu_ready),
        .o_lsu_rvalid (o_lsu_rvalid),
        .o_lsu_rdata  (o_lsu_rdata),
        .i_lsu_rready (i_lsu_rready),
        .o_mem_valid  (o_mem_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_mem_rready (o_mem_rready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        i_ifu_valid  = 1'b0;
        i_ifu_addr   = '0;
        i_ifu_rready = 1'b0;
        i_lsu_valid  = 1'b0;
        i_lsu_addr   = '0;
        i_lsu_wen    = 1'b0;
        i_lsu_wdata  = '0;
        i_lsu_wmask  = '0;
        i_lsu_rready = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        cyc();
        cyc();
        settle();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        cyc();
        i_rst_n = 1'b1;
    endtask

    task automatic test_ifu_only();
        cyc();
        i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0000;
        settle();
        checks++; if ({o_ifu_ready, o_lsu_ready, o_mem_valid} !== 3'b100) begin errors++; $display("FAIL ifu_only_accept: got %b expected 100", {o_ifu_ready, o_lsu_ready, o_mem_valid}); end
        cyc();
        i_ifu_valid = 1'b0; i_ifu_addr = 32'h0; i_mem_ready = 1'b1;
        settle();
        checks++; if ({o_mem_valid, o_mem_wen, o_mem_wmask, o_ifu_ready} !== 7'b1000000) begin errors++; $display("FAIL ifu_only_req_ctl: got %b expected 1000000", {o_mem_valid, o_mem_wen, o_mem_wmask, o_ifu_ready}); end
        checks++; if (o_mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_only_addr: got %h expected 80000000", o_mem_addr); end
        cyc();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0413; i_ifu_rready = 1'b1;
        settle();
        checks++; if ({o_ifu_rvalid, o_lsu_rvalid, o_mem_rready, o_mem_valid} !== 4'b1010) begin errors++; $display("FAIL ifu_only_resp_ctl: got %b expected 1010", {o_ifu_rvalid, o_lsu_rvalid, o_mem_rready, o_mem_valid}); end
        checks++; if (o_ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_only_rdata: got %h expected 00000413", o_ifu_rdata); end
        checks++; if (o_lsu_rdata !== 32'h0) begin errors++; $display("FAIL ifu_only_lsu_rdata: got %h expected 0", o_lsu_rdata); end
        cyc();
        i_mem_rvalid = 1'b0; i_ifu_rready = 1'b0;
        settle();
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL ifu_only_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_tie();
        // Reset state again so the tie is decided by the post-reset last_grant.
        test_reset();
        cyc();
        i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0004;
        i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_1000; i_lsu_wen = 1'b0;
        settle();
        checks++; if ({o_ifu_ready, o_lsu_ready} !== 2'b10) begin errors++; $display("FAIL tie_first_grant: got %b expected 10", {o_ifu_ready, o_lsu_ready}); end
        cyc();
        i_ifu_valid = 1'b0; i_mem_ready = 1'b1;
        settle();
        checks++; if ({o_mem_valid, o_lsu_ready} !== 2'b10 || o_mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL tie_ifu_req: got v/rdy %b addr %h expected 10 80000004", {o_mem_valid, o_lsu_ready}, o_mem_addr); end
        cyc();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678; i_ifu_rready = 1'b1;
        settle();
        checks++; if ({o_ifu_rvalid, o_lsu_rvalid, o_lsu_ready} !== 3'b100) begin errors++; $display("FAIL tie_ifu_resp: got %b expected 100", {o_ifu_rvalid, o_lsu_rvalid, o_lsu_ready}); end
        cyc();
        i_mem_rvalid = 1'b0; i_ifu_rready = 1'b0;
        settle();
        checks++; if ({o_ifu_ready, o_lsu_ready} !== 2'b01) begin errors++; $display("FAIL tie_second_grant: got %b expected 01", {o_ifu_ready, o_lsu_ready}); end
        cyc();
        i_lsu_valid = 1'b0; i_mem_ready = 1'b1;
        settle();
        checks++; if ({o_mem_valid, o_mem_wen} !== 2'b10 || o_mem_addr !== 32'h8000_1000) begin errors++; $display("FAIL tie_lsu_req: got v/wen %b addr %h expected 10 80001000", {o_mem_valid, o_mem_wen}, o_mem_addr); end
        cyc();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_0001; i_lsu_rready = 1'b1;
        settle();
        checks++; if ({o_lsu_rvalid, o_ifu_rvalid} !== 2'b10 || o_lsu_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL tie_lsu_resp: got %b data %h expected 10 cafe0001", {o_lsu_rvalid, o_ifu_rvalid}, o_lsu_rdata); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_sustained();
        logic        exp_lsu;
        logic [31:0] exp_addr;
        // last grant is LSU here, so IFU leads and the order alternates.
        for (int k = 0; k < 6; k++) begin
            exp_lsu  = k[0];
            exp_addr = exp_lsu ? (32'h9000_0000 + 32'(k) * 4) : (32'h8000_0100 + 32'(k) * 4);
            i_mem_rvalid = 1'b0;
            i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0100 + 32'(k) * 4;
            i_lsu_valid = 1'b1; i_lsu_addr = 32'h9000_0000 + 32'(k) * 4; i_lsu_wen = 1'b0;
            settle();
            checks++; if ({o_ifu_ready, o_lsu_ready} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL sustained_grant_%0d: got %b expected %b", k, {o_ifu_ready, o_lsu_ready}, {~exp_lsu, exp_lsu}); end
            cyc();
            i_mem_ready = 1'b1;
            settle();
            checks++; if (o_mem_valid !== 1'b1 || o_mem_addr !== exp_addr || {o_ifu_ready, o_lsu_ready} !== 2'b00) begin errors++; $display("FAIL sustained_req_%0d: got v %b addr %h rdy %b expected 1 %h 00", k, o_mem_valid, o_mem_addr, {o_ifu_ready, o_lsu_ready}, exp_addr); end
            cyc();
            i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'(k); i_ifu_rready = 1'b1; i_lsu_rready = 1'b1;
            settle();
            checks++; if ({o_ifu_rvalid, o_lsu_rvalid} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL sustained_resp_%0d: got %b expected %b", k, {o_ifu_rvalid, o_lsu_rvalid}, {~exp_lsu, exp_lsu}); end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_lsu_write();
        int rv_count;
        rv_count = 0;
        i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_2000; i_lsu_wen = 1'b1;
        i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_wmask = 4'b0011; i_lsu_rready = 1'b1;
        settle();
        checks++; if ({o_lsu_ready, o_ifu_ready} !== 2'b10) begin errors++; $display("FAIL write_accept: got %b expected 10", {o_lsu_ready, o_ifu_ready}); end
        for (int s = 0; s < 4; s++) begin
            cyc();
            // Change the LSU bus after acceptance; the memory payload must not follow.
            i_lsu_valid = 1'b0; i_lsu_addr = 32'h1111_1111; i_lsu_wdata = 32'h0; i_lsu_wmask = 4'b1100; i_lsu_wen = 1'b0;
            i_mem_ready = (s == 3);
            settle();
            checks++; if ({o_mem_valid, o_mem_wen, o_mem_wmask} !== 6'b110011 || o_mem_addr !== 32'h8000_2000 || o_mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_payload_%0d: got ctl %b addr %h data %h expected 110011 80002000 deadbeef", s, {o_mem_valid, o_mem_wen, o_mem_wmask}, o_mem_addr, o_mem_wdata); end
            if (o_lsu_rvalid) rv_count++;
        end
        cyc();
        i_mem_ready = 1'b0;
        settle();
        checks++; if ({o_lsu_rvalid, o_mem_rready, o_mem_valid} !== 3'b010) begin errors++; $display("FAIL write_wait_resp: got %b expected 010", {o_lsu_rvalid, o_mem_rready, o_mem_valid}); end
        if (o_lsu_rvalid) rv_count++;
        cyc();
        i_mem_rvalid = 1'b1;
        settle();
        checks++; if ({o_lsu_rvalid, o_ifu_rvalid} !== 2'b10) begin errors++; $display("FAIL write_ack: got %b expected 10", {o_lsu_rvalid, o_ifu_rvalid}); end
        if (o_lsu_rvalid) rv_count++;
        cyc();
        i_mem_rvalid = 1'b0;
        settle();
        if (o_lsu_rvalid) rv_count++;
        checks++; if (rv_count !== 1) begin errors++; $display("FAIL write_ack_count: got %0d expected 1", rv_count); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL write_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        cyc();
        i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0040;
        settle();
        checks++; if (o_ifu_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", o_ifu_ready); end
        cyc();
        i_ifu_valid = 1'b0; i_mem_ready = 1'b1;
        cyc();
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hABCD_0000; i_ifu_rready = 1'b0; i_lsu_rready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            settle();
            checks++; if ({o_mem_rready, o_ifu_rvalid, o_lsu_rvalid} !== 3'b010) begin errors++; $display("FAIL bp_stall_%0d: got %b expected 010", s, {o_mem_rready, o_ifu_rvalid, o_lsu_rvalid}); end
            cyc();
        end
        i_ifu_rready = 1'b1;
        settle();
        checks++; if ({o_mem_rready, o_ifu_rvalid, o_lsu_rvalid} !== 3'b110 || o_ifu_rdata !== 32'hABCD_0000) begin errors++; $display("FAIL bp_complete: got %b data %h expected 110 abcd0000", {o_mem_rready, o_ifu_rvalid, o_lsu_rvalid}, o_ifu_rdata); end
        cyc();
        i_mem_rvalid = 1'b0;
        settle();
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL bp_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_resp();
        // Last grant is IFU now, so without a reset a tie would go to LSU.
        cyc();
        i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0080;
        cyc();
        i_ifu_valid = 1'b0; i_mem_ready = 1'b1;
        cyc();
        i_mem_ready = 1'b0;
        settle();
        checks++; if (dut.state_q !== ST_RESP) begin errors++; $display("FAIL rst_mid_in_resp: got %0d expected %0d", dut.state_q, ST_RESP); end
        i_rst_n = 1'b0;
        cyc();
        i_rst_n = 1'b1;
        // A stray memory response after reset must not reach either master.
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA; i_ifu_rready = 1'b1; i_lsu_rready = 1'b1;
        settle();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", all_out); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        cyc();
        clear_inputs();
        i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0000;
        i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_3000;
        settle();
        checks++; if ({o_ifu_ready, o_lsu_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie: got %b expected 10", {o_ifu_ready, o_lsu_ready}); end
        cyc();
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_ifu_only();
        test_tie();
        test_sustained();
        test_lsu_write();
        test_backpressure();
        test_reset_mid_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
